// File: rtl/tff_count_sequencer.sv
// Sequencer for an external bank of T flip-flops: clears the bank, then drives its T inputs
// so the bank counts up or down to a captured target, reporting completion and step count.
module tff_count_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_cp,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_ff_q,
    output logic [WIDTH-1:0] o_ff_t,
    output logic             o_ff_n_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_steps
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH:0]   r_steps;
    logic             r_busy;
    logic             r_done;

    logic             w_match;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_down;

    assign w_match = (i_ff_q == r_target);

    // Toggle enables: bit i flips when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        w_t_up      = '0;
        w_t_down    = '0;
        w_t_up[0]   = 1'b1;
        w_t_down[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            w_t_up[i]   = w_t_up[i-1] & i_ff_q[i-1];
            w_t_down[i] = w_t_down[i-1] & ~i_ff_q[i-1];
        end
    end

    always_comb begin
        o_ff_t = '0;
        if (r_state == StRun && !i_rst && !i_abort && !w_match) begin
            o_ff_t = r_dir ? w_t_up : w_t_down;
        end
    end

    // Clear follows rst combinationally so the bank clears on the same edge as this block.
    assign o_ff_n_rst = ~(i_rst || (r_state == StClear));
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_steps    = r_steps;

    always_ff @(posedge i_cp) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_dir    <= 1'b0;
            r_target <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_dir    <= i_dir;
                        r_target <= i_target;
                        r_steps  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= StClear;
                    end
                end
                StClear: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (w_match) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_steps <= r_steps + (WIDTH+1)'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer with a behavioural T flip-flop bank closing the feedback loop.
module tb_tff_count_sequencer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] target;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] ff_t;
    logic             ff_n_rst;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   steps;

    int n_checks;
    int n_fail;

    tff_count_sequencer #(.WIDTH(WIDTH)) dut (
        .i_cp      (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_dir     (dir),
        .i_target  (target),
        .i_abort   (abort),
        .i_ff_q    (q),
        .o_ff_t    (ff_t),
        .o_ff_n_rst(ff_n_rst),
        .o_busy    (busy),
        .o_done    (done),
        .o_steps   (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank of T flip-flops with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!ff_n_rst) q <= '0;
        else           q <= q ^ ff_t;
    end

    typedef struct {
        logic             dir;
        logic [WIDTH-1:0] target;
        int               exp_steps;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic d, input logic [WIDTH-1:0] tg);
        dir    = d;
        target = tg;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        target = ~tg;  // must be ignored once latched
    endtask

    task automatic wait_q(input logic [WIDTH-1:0] val);
        int n;
        n = 0;
        while (q != val && n < 40) begin
            tick();
            n++;
        end
        check("wait_q_reached", int'(q), int'(val));
    endtask

    initial begin
        int lat;
        int done_cnt;
        logic [WIDTH-1:0] t_or;
        int down_seq[4];

        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        dir      = 1'b0;
        target   = '0;
        abort    = 1'b0;

        vecs[0] = '{dir: 1'b1, target: 4'd5,  exp_steps: 5};
        vecs[1] = '{dir: 1'b0, target: 4'd13, exp_steps: 3};
        vecs[2] = '{dir: 1'b1, target: 4'd0,  exp_steps: 0};
        vecs[3] = '{dir: 1'b1, target: 4'd15, exp_steps: 15};
        vecs[4] = '{dir: 1'b0, target: 4'd0,  exp_steps: 0};
        vecs[5] = '{dir: 1'b0, target: 4'd1,  exp_steps: 15};
        vecs[6] = '{dir: 1'b1, target: 4'd9,  exp_steps: 9};
        vecs[7] = '{dir: 1'b0, target: 4'd8,  exp_steps: 8};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("rst_n_rst", int'(ff_n_rst), 0);
        check("rst_ff_t", int'(ff_t), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_steps", int'(steps), 0);
        check("rst_q", int'(q), 0);
        rst = 1'b0;
        tick();
        check("idle_n_rst", int'(ff_n_rst), 1);

        // Table-driven full sequences
        foreach (vecs[k]) begin
            pulse_start(vecs[k].dir, vecs[k].target);
            check("clear_busy", int'(busy), 1);
            check("clear_n_rst", int'(ff_n_rst), 0);
            lat  = 1;
            t_or = '0;
            while (!done && lat < 40) begin
                tick();
                t_or = t_or | ff_t;
                lat++;
            end
            check("latency", lat, vecs[k].exp_steps + 3);
            check("steps", int'(steps), vecs[k].exp_steps);
            check("final_q", int'(q), int'(vecs[k].target));
            check("done_ff_t", int'(ff_t), 0);
            check("done_busy", int'(busy), 0);
            if (vecs[k].exp_steps == 0) check("zero_tgt_t_never", int'(t_or), 0);
            tick();
            check("done_one_cycle", int'(done), 0);
            check("steps_hold", int'(steps), vecs[k].exp_steps);
            check("q_hold", int'(q), int'(vecs[k].target));
            tick();
        end

        // Down wrap: bank walks 0, 15, 14, 13
        down_seq = '{0, 15, 14, 13};
        pulse_start(1'b0, 4'd13);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("down_wrap_q", int'(q), down_seq[i]);
        end
        tick();
        check("down_wrap_done", int'(done), 1);
        check("down_wrap_steps", int'(steps), 3);
        tick();

        // Abort at Q=4
        pulse_start(1'b1, 4'd10);
        wait_q(4'd4);
        check("pre_abort_steps", int'(steps), 4);
        abort = 1'b1;
        #1;
        check("abort_ff_t", int'(ff_t), 0);
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_q", int'(q), 4);
        check("abort_steps", int'(steps), 4);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_q_still", int'(q), 4);
        pulse_start(1'b1, 4'd2);
        tick();
        check("restart_q_cleared", int'(q), 0);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("restart_done", int'(done), 1);
        check("restart_steps", int'(steps), 2);
        tick();

        // Reset mid-run at Q=6
        pulse_start(1'b1, 4'd12);
        wait_q(4'd6);
        rst = 1'b1;
        #1;
        check("midrst_n_rst", int'(ff_n_rst), 0);
        check("midrst_ff_t", int'(ff_t), 0);
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_steps", int'(steps), 0);
        check("midrst_q", int'(q), 0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("midrst_no_done", done_cnt, 0);

        // Start ignored while busy
        pulse_start(1'b1, 4'd3);
        start = 1'b1;
        target = 4'd1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("busy_start_ignored_steps", int'(steps), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller for an external bank of WIDTH `T_ff` instances (ports T, CP, n_rst, Q, Qbar).
- Drives each flip-flop's T input and shared n_rst so the bank behaves as a synchronous up/down counter.
- On start, clears the bank, counts to a programmed target, stops and reports completion and step count.
- Sits beside the FF bank; the bank's Q outputs feed back into this block.

Parameters:
- WIDTH, 4, number of T flip-flops in the controlled bank.

Ports:
- CP  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- dir  input  1  count direction captured at start: 1 = up, 0 = down.
- target  input  WIDTH  stop value captured at start.
- abort  input  1  terminates an active sequence.
- ff_q  input  WIDTH  Q outputs of the flip-flop bank (bit 0 = LSB).
- ff_t  output  WIDTH  T inputs to the flip-flop bank.
- ff_n_rst  output  1  active-low clear to the bank.
- busy  output  1  high in CLEAR or RUN.
- done  output  1  one-cycle pulse when the target is reached.
- steps  output  WIDTH+1  toggle cycles issued in the current or last sequence.

Behaviour:
- Reset (rst=1 at a CP edge):
  - state=IDLE, steps=0, done=0.
  - ff_n_rst=0 while rst is high, so the bank is also cleared.
  - ff_t=0, busy=0.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - ff_t=0, ff_n_rst=1.
  - start=1: latch dir and target, steps<=0, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - ff_n_rst=0, ff_t=0, go to RUN. The bank reads 0 from the next cycle.
- RUN:
  - ff_t is combinational from ff_q and latched dir.
  - Up: ff_t[0]=1; ff_t[i]=AND of ff_q[i-1:0].
  - Down: ff_t[0]=1; ff_t[i]=AND of ~ff_q[i-1:0].
  - If ff_q==latched target: ff_t=0 in that same cycle and next state is DONE.
  - Otherwise steps<=steps+1 per cycle.
- DONE (1 cycle):
  - done=1, ff_t=0, ff_n_rst=1, go to IDLE. steps holds until the next start.
- Wrap-around:
  - Up from all-ones wraps to 0; down from 0 wraps to all-ones.
  - Any target is reached within 2^WIDTH RUN cycles. Steps never overflow (max 2^WIDTH - 1).
- target=0: RUN sees ff_q==0 in its first cycle, so done occurs with steps=0.
- abort:
  - abort=1 in CLEAR or RUN: next state IDLE, ff_t=0 that cycle, no done pulse.
  - Bank keeps its current value; steps holds.
  - Ignored in IDLE and DONE.
- Precedence:
  - rst beats abort, and abort beats a target match in the same cycle.
  - start outside IDLE is ignored.
- Latency: start edge to done pulse = 1 (CLEAR) + steps + 1 (RUN match cycle) + 1 (DONE) cycles.
- busy=1 exactly in CLEAR and RUN.

Test Plan:
- Reset: rst=1 for 2 cycles -> ff_n_rst=0, ff_t=0, busy=0, done=0, steps=0; bank Q=0.
- Up count: dir=1, target=5, start pulse -> CLEAR 1 cycle; Q steps 1,2,3,4,5; done pulses once 1 cycle after Q==5; steps=5; Q holds 5.
- Down wrap: dir=0, target=13 (WIDTH=4) -> Q 0,15,14,13; done; steps=3; ff_t=0 after match.
- Zero target: target=0, dir=1 -> done 3 cycles after start (CLEAR, RUN, DONE); steps=0; ff_t never nonzero.
- Abort: dir=1, target=10, abort raised when Q=4 -> no done, busy drops next cycle, Q stays 4, steps=4; a new start then clears Q to 0 and counts again.
- Reset mid-run: rst=1 while Q=6 in RUN -> next edge state IDLE, Q cleared to 0, steps=0, no done pulse.
